// File: rtl/vga_timing.sv
// Raster timing generator: divided pixel tick, h/v counters and a registered,
// mutually aligned output stage (sync, de, coordinates, sol/sof, frame count).
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 12,
  parameter int FCW      = 12
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_en,
  output logic           o_pix_ce,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_de,
  output logic [CW-1:0]  o_x,
  output logic [CW-1:0]  o_y,
  output logic           o_sol,
  output logic           o_sof,
  output logic [FCW-1:0] o_frame_cnt
);

  localparam int HTOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STAGES = 1;

  localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          sol;
    logic          sof;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pix_t;

  logic [DW-1:0]  div;
  logic [CW-1:0]  hc, vc;
  logic           ce, h_last, v_last, seen_sof;
  logic [FCW-1:0] frame_cnt;
  logic [31:0]    hc32, vc32;
  logic [STAGES:0] vld_pipe;
  pix_t           pix_d, pix_q;

  assign ce     = i_en && (div == DW'(CLK_DIV - 1));
  assign h_last = (hc == CW'(HTOT - 1));
  assign v_last = (vc == CW'(VTOT - 1));
  assign hc32   = 32'(hc);
  assign vc32   = 32'(vc);
  assign vld_pipe[0] = ce;

  // Divider only runs while enabled, so a pause resumes mid-pixel exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div <= '0;
      hc  <= '0;
      vc  <= '0;
    end else if (i_en) begin
      div <= ce ? '0 : div + 1'b1;
      if (ce) begin
        hc <= h_last ? '0 : hc + 1'b1;
        if (h_last) vc <= v_last ? '0 : vc + 1'b1;
      end
    end
  end

  always_comb begin
    pix_d       = pix_q;
    pix_d.x     = hc;
    pix_d.y     = vc;
    pix_d.de    = (hc32 < H_ACT) && (vc32 < V_ACT);
    pix_d.hsync = (hc32 >= HS_BEG && hc32 < HS_END) ? HS_POL : ~HS_POL;
    pix_d.vsync = (vc32 >= VS_BEG && vc32 < VS_END) ? VS_POL : ~VS_POL;
    pix_d.sol   = (hc == '0);
    pix_d.sof   = (hc == '0) && (vc == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_q <= '{hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b0, sol: 1'b0,
                 sof: 1'b0, x: '0, y: '0};
      vld_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (ce) pix_q <= pix_d;
    end
  end

  // The first start-of-frame after reset is frame 0, so it does not count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt <= '0;
      seen_sof  <= 1'b0;
    end else if (ce && pix_d.sof) begin
      if (seen_sof) frame_cnt <= frame_cnt + 1'b1;
      seen_sof <= 1'b1;
    end
  end

  assign o_pix_ce    = vld_pipe[STAGES];
  assign o_hsync     = pix_q.hsync;
  assign o_vsync     = pix_q.vsync;
  assign o_de        = pix_q.de;
  assign o_x         = pix_q.x;
  assign o_y         = pix_q.y;
  assign o_sol       = pix_q.sol;
  assign o_sof       = pix_q.sof;
  assign o_frame_cnt = frame_cnt;

endmodule

// File: doc/vga_timing.md
# vga_timing

Parametrised raster timing generator; successor to the fixed 640x480 hsync/vsync pair. Produces sync, data-enable, pixel coordinates, line/frame markers and a frame counter from one system clock, using an internal pixel-clock-enable divider instead of a derived clock. It sits between the board clock and any pixel renderer: the renderer samples `o_x`/`o_y`/`o_de` on `o_pix_ce` and drives RGB.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HS_POL`, 0: hsync active level (0 = active-low)
- `VS_POL`, 0: vsync active level
- `CLK_DIV`, 2: `i_clk` cycles per pixel; must be >= 1
- `CW`, 12: coordinate width; HTOT and VTOT must be <= 2^CW
- `FCW`, 12: frame counter width

Ports:
- `i_clk` in 1: system clock
- `i_rst_n` in 1: asynchronous active-low reset
- `i_en` in 1: run enable; low freezes all state
- `o_pix_ce` out 1: one-cycle strobe; outputs below are new in this cycle
- `o_hsync` out 1: horizontal sync, polarity per `HS_POL`
- `o_vsync` out 1: vertical sync, polarity per `VS_POL`
- `o_de` out 1: high in the visible region
- `o_x` out CW: horizontal position, 0..HTOT-1
- `o_y` out CW: vertical position, 0..VTOT-1
- `o_sol` out 1: high for pixel x=0 of every line
- `o_sof` out 1: high for pixel (0,0)
- `o_frame_cnt` out FCW: completed-frame count, modulo 2^FCW

## Operation

- HTOT = H_ACTIVE+H_FP+H_SYNC+H_BP; VTOT = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider `div` counts 0..CLK_DIV-1 while `i_en`=1. Internal tick `ce` = `i_en` and (`div`==CLK_DIV-1). With CLK_DIV=1, `ce`=`i_en` every cycle.
- Counters `hc` (0..HTOT-1) and `vc` (0..VTOT-1) advance only on `ce`:
  - `hc` wraps HTOT-1 -> 0.
  - `vc` increments only when `hc` wraps, and wraps VTOT-1 -> 0.
- On each `ce`, all outputs are loaded in the same edge from the current (`hc`,`vc`) before the counters advance, so outputs are mutually aligned:
  - `o_x`=`hc`, `o_y`=`vc`
  - `o_de` = `hc`<H_ACTIVE and `vc`<V_ACTIVE
  - `o_hsync` = HS_POL when H_ACTIVE+H_FP <= `hc` < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - `o_vsync` uses the same rule with the V_* parameters and `vc`
  - `o_sol` = (`hc`==0); `o_sof` = (`hc`==0 and `vc`==0)
- `o_frame_cnt` increments (wrapping) on the `ce` that loads `o_sof`=1, except the first such load after reset. The first frame after reset therefore reads 0.
- All pixel-rate outputs hold their value for the whole pixel period, until the next `ce`.
- `o_pix_ce` is the registered `ce`. It is high in exactly the cycle where the new values first appear.
- `i_en`=0:
  - `div`, counters and all outputs hold; `o_pix_ce`=0.
  - On re-enable, counting resumes from the held state with no pixel skipped or repeated.
- Reset values (asynchronous, while `i_rst_n`=0):
  - `div`=0, `hc`=0, `vc`=0
  - `o_pix_ce`=0, `o_de`=0, `o_x`=0, `o_y`=0, `o_sol`=0, `o_sof`=0, `o_frame_cnt`=0
  - `o_hsync`=~HS_POL, `o_vsync`=~VS_POL
- Reset asserted mid-frame clears everything immediately. After release the sequence restarts exactly as from power-up.

## Timing

- After `i_rst_n` rises, with `i_en`=1, the first `ce` is at the CLK_DIV-th rising edge. At that edge the outputs show (0,0): `o_de`=1, `o_sol`=1, `o_sof`=1. `o_pix_ce` is high during the following cycle.
- Pixel period is CLK_DIV clocks. Line period is HTOT*CLK_DIV clocks. Frame period is HTOT*VTOT*CLK_DIV clocks.
- Output latency is one pixel period behind the internal counter; it is fixed and requires no compensation by consumers.
- hsync edges align with the `o_x` transition into and out of the sync window. vsync edges align with the `o_sol` pixel of the first sync line and of the first back-porch line.

## Test plan

- Reset: hold `i_rst_n`=0 with `i_en`=1 -> all outputs at the reset values, `o_hsync`=`o_vsync`=1 (defaults); release -> first `o_pix_ce` with `o_x`=0, `o_y`=0, `o_sof`=1, `o_de`=1.
- Default line: `o_de` high for 640 pixels (1280 clocks). `o_hsync` low from `o_x`=656 to `o_x`=751, i.e. 96 pixels (192 clocks). Line period is 1600 clocks.
- Default frame: `o_sof` period is 840000 clocks. `o_vsync` low for `o_y`=490..491. `o_frame_cnt` reads 0, 1, 2 on successive frames.
- Small config (H=4/1/1/1, V=3/1/1/1, CLK_DIV=1, HS_POL=1, FCW=2): hsync high only at x=5; `o_frame_cnt` wraps 3 -> 0 after the 4th completed frame.
- Enable gating: drop `i_en` for 37 clocks mid-line at `o_x`=100 -> outputs frozen with no `o_pix_ce`; after re-enable the next `o_x` is 101.
- Mid-frame reset at `o_y`=300: outputs clear asynchronously; after release, `o_sof` appears and `o_frame_cnt`=0.
